// File: rtl/mul_result_queue.sv
// rtl/mul_result_queue.sv - formats multiplier products and queues them for a valid/ready consumer
module mul_result_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic [63:0]   product,
  input  logic [1:0]    mode,
  output logic          mul_ready,
  output logic          res_valid,
  output logic [31:0]   res_data,
  output logic          res_ovf,
  input  logic          res_ready,
  output logic [CW-1:0] count,
  output logic          drop_err,
  input  logic          clr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Each entry is {ovf, formatted result}
  logic [32:0]   mem_q [DEPTH];
  logic [32:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          drop_err_q, drop_err_d;

  logic          cap, pop, push, ovf;
  logic [31:0]   fmt_data;

  // Edge detect on done, product formatting and overflow classification
  always_comb begin
    cap = done & ~done_q;
    ovf = ~(&product[63:31] | ~|product[63:31]);
    case (mode)
      2'b01:   fmt_data = product[63:32];
      2'b10:   fmt_data = ovf ? (product[63] ? 32'h8000_0000 : 32'h7FFF_FFFF) : product[31:0];
      default: fmt_data = product[31:0];
    endcase
  end

  // Next-state for the queue: a pop frees the slot a same-cycle push needs when full
  always_comb begin
    pop        = res_valid & res_ready;
    push       = cap & ((count_q < DEPTH_C) | pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    done_d     = done;
    drop_err_d = drop_err_q;

    if (push) begin
      mem_d[wr_ptr_q] = {ovf, fmt_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A lost capture outranks a clear in the same cycle
    if (cap & ~push) begin
      drop_err_d = 1'b1;
    end else if (clr_err) begin
      drop_err_d = 1'b0;
    end
  end

  // State registers with synchronous flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Head of queue falls through; outputs read zero while empty
  always_comb begin
    res_valid = (count_q != '0);
    res_data  = res_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    res_ovf   = res_valid ? mem_q[rd_ptr_q][32] : 1'b0;
    mul_ready = (count_q < DEPTH_C);
    count     = count_q;
    drop_err  = drop_err_q;
  end

endmodule
